// File: rtl/store_op_gather.sv
// Gathers one store operand per lane into a full-width beat toward memory, tracking beats
// per instruction and reporting completion with the instruction ID.
module store_op_gather #(
    parameter int unsigned NrLanes   = 4,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [15:0]                  req_beats_i,
    input  logic [IdWidth-1:0]           req_id_i,
    input  logic [NrLanes-1:0]           lane_valid_i,
    output logic [NrLanes-1:0]           lane_ready_o,
    input  logic [NrLanes*DataWidth-1:0] lane_data_i,
    output logic                         mem_valid_o,
    input  logic                         mem_ready_i,
    output logic [NrLanes*DataWidth-1:0] mem_data_o,
    output logic                         mem_last_o,
    output logic                         done_o,
    output logic [IdWidth-1:0]           done_id_o,
    input  logic                         done_gnt_i
);

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    state_e                       state_q, state_d;
    logic [15:0]                  beats_q, beats_d;
    logic [15:0]                  pack_cnt_q, pack_cnt_d;
    logic [IdWidth-1:0]           id_q, id_d;
    logic [NrLanes-1:0]           buf_full_q, buf_full_d;
    logic [NrLanes*DataWidth-1:0] buf_data_q, buf_data_d;
    logic                         out_valid_q, out_valid_d;
    logic                         out_last_q, out_last_d;
    logic [NrLanes*DataWidth-1:0] out_data_q, out_data_d;

    logic [NrLanes-1:0]           lane_hs;
    logic [NrLanes-1:0]           eff_full;
    logic [NrLanes*DataWidth-1:0] pack_data;
    logic                         pack;

    assign req_ready_o = (state_q == StIdle);
    assign lane_ready_o = (state_q == StCollect && pack_cnt_q < beats_q) ? ~buf_full_q : '0;
    assign mem_valid_o = out_valid_q;
    assign mem_data_o  = out_data_q;
    assign mem_last_o  = out_last_q;
    assign done_o      = (state_q == StDone);
    assign done_id_o   = id_q;

    always_comb begin
        state_d     = state_q;
        beats_d     = beats_q;
        pack_cnt_d  = pack_cnt_q;
        id_d        = id_q;
        buf_full_d  = buf_full_q;
        buf_data_d  = buf_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        pack_data   = '0;

        lane_hs = lane_valid_i & lane_ready_o;
        // A lane handshaking this cycle counts as full so the beat forms without a bubble.
        eff_full = buf_full_q | lane_hs;
        for (int i = 0; i < NrLanes; i++) begin
            pack_data[i*DataWidth +: DataWidth] = buf_full_q[i] ?
                buf_data_q[i*DataWidth +: DataWidth] : lane_data_i[i*DataWidth +: DataWidth];
        end
        pack = (state_q == StCollect) && (&eff_full) && (!out_valid_q || mem_ready_i);

        if (out_valid_q && mem_ready_i) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (pack) begin
            out_valid_d = 1'b1;
            out_data_d  = pack_data;
            out_last_d  = (pack_cnt_q == beats_q - 16'd1);
            pack_cnt_d  = pack_cnt_q + 16'd1;
            buf_full_d  = '0;
        end else begin
            buf_full_d = buf_full_q | lane_hs;
            for (int i = 0; i < NrLanes; i++) begin
                if (lane_hs[i]) begin
                    buf_data_d[i*DataWidth +: DataWidth] = lane_data_i[i*DataWidth +: DataWidth];
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    beats_d    = req_beats_i;
                    id_d       = req_id_i;
                    pack_cnt_d = '0;
                    buf_full_d = '0;
                    state_d    = (req_beats_i == 16'd0) ? StDone : StCollect;
                end
            end
            StCollect: begin
                if (out_valid_q && mem_ready_i && out_last_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (done_gnt_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            beats_q     <= '0;
            pack_cnt_q  <= '0;
            id_q        <= '0;
            buf_full_q  <= '0;
            buf_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            beats_q     <= beats_d;
            pack_cnt_q  <= pack_cnt_d;
            id_q        <= id_d;
            buf_full_q  <= buf_full_d;
            buf_data_q  <= buf_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: doc/store_op_gather.md
STORE_OP_GATHER -- requirements
Module: store_op_gather

Interface
REQ-001 SHALL have parameter NrLanes, default 4, number of lanes whose store operands are gathered.
REQ-002 SHALL have parameter DataWidth, default 64, width of one lane store operand (vrf_data_t).
REQ-003 SHALL have parameter IdWidth, default 3, width of insn_id_t.
REQ-004 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 req_valid_i  input  1  new store instruction request.
REQ-007 req_ready_o  output  1  request accepted when high together with req_valid_i.
REQ-008 req_beats_i  input  16  number of gathered beats for the instruction.
REQ-009 req_id_i  input  IdWidth  instruction ID.
REQ-010 lane_valid_i  input  NrLanes  per-lane store operand valid (lane store_op_valid_o).
REQ-011 lane_ready_o  output  NrLanes  per-lane store operand ready (lane store_op_ready_i).
REQ-012 lane_data_i  input  NrLanes*DataWidth  per-lane operand; lane i at bits [i*DataWidth +: DataWidth].
REQ-013 mem_valid_o  output  1  gathered beat valid toward memory.
REQ-014 mem_ready_i  input  1  memory accepts the beat.
REQ-015 mem_data_o  output  NrLanes*DataWidth  gathered beat, same lane packing as lane_data_i.
REQ-016 mem_last_o  output  1  beat is the final beat of the instruction.
REQ-017 done_o  output  1  instruction completion report.
REQ-018 done_id_o  output  IdWidth  ID of the completed instruction.
REQ-019 done_gnt_i  input  1  completion report consumed.

Function
REQ-020 SHALL implement states IDLE, COLLECT, DONE.
REQ-021 req_ready_o SHALL be 1 only in IDLE.
REQ-022 On req_valid_i && req_ready_o, SHALL latch req_beats_i and req_id_i, clear the beat counters, and go to COLLECT; with req_beats_i == 0 it SHALL go directly to DONE.
REQ-023 Each lane SHALL have a one-entry capture buffer; lane_ready_o[i] = (state == COLLECT) && !buf_full[i] && (pack_cnt < beats).
REQ-024 A lane handshake (lane_valid_i[i] && lane_ready_o[i]) SHALL write lane_data_i slice i into buffer i and set buf_full[i]; lanes are captured independently, in any order.
REQ-025 When all buf_full bits are set and the output register is empty or mem_ready_i is high in the same cycle, SHALL move all buffers into the output register, clear all buf_full, assert mem_valid_o next cycle, and increment pack_cnt.
REQ-026 mem_last_o SHALL be 1 when the beat in the output register has index beats-1.
REQ-027 Output SHALL hold mem_valid_o, mem_data_o and mem_last_o stable while mem_valid_o && !mem_ready_i.
REQ-028 Throughput SHALL be one beat per cycle with all lanes valid and mem_ready_i high; latency from the last lane handshake to mem_valid_o is 1 cycle.
REQ-029 On mem_valid_o && mem_ready_i && mem_last_o, SHALL go to DONE.
REQ-030 In DONE, done_o = 1 and done_id_o = latched ID; on done_gnt_i go to IDLE; done_o held until granted.
REQ-031 In IDLE and DONE, lane_ready_o SHALL be all zeros and no lane data captured.
REQ-032 A lane SHALL never be more than one beat ahead of the slowest lane; the total beats accepted per lane SHALL equal beats.
REQ-033 Counters SHALL be 16 bits; no wrap-around possible since pack_cnt <= beats.

Reset
REQ-034 On rst_ni low, asynchronously: state = IDLE, buf_full = 0, mem_valid_o = 0, mem_last_o = 0, done_o = 0, pack_cnt = 0; registered data/ID fields reset to 0.
REQ-035 Reset mid-instruction SHALL discard all buffered and in-flight beats with no done_o generated.
REQ-036 After reset release, req_ready_o = 1 and lane_ready_o = 0.

Verification
REQ-037 NrLanes=4, req_beats=3, all lanes valid, mem_ready=1 -> 3 beats on consecutive cycles, mem_last on beat 3, then done_o with the request ID.
REQ-038 Lane 2 valid 5 cycles later than the others -> lanes 0,1,3 ready drop after capture; beat issued 1 cycle after lane 2 handshake.
REQ-039 mem_ready_i held 0 for 4 cycles with a beat pending -> mem_data_o stable, lane buffers refill once, then stall.
REQ-040 req_beats=0 -> DONE in the next cycle, no mem_valid_o, lane_ready_o stays 0.
REQ-041 done_gnt_i withheld 3 cycles -> done_o stays 1, req_ready_o stays 0; grant -> IDLE.
REQ-042 rst_ni asserted during COLLECT with a beat pending -> all outputs return to reset values immediately; the next request starts clean.
